// File: rtl/ahb_arbiter_mn.sv
// Parametrised multi-master AHB arbiter: round-robin or fixed priority, burst-aware grant hold,
// HLOCK/HMASTLOCK, default master. Define AMBA_AHB_ARB_SPLIT_EN to add HRESP/HSPLIT split masking.
module ahb_arbiter_mn #(
    parameter int NUM_MASTER     = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int ROUND_ROBIN    = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HREADY,
    input  logic [NUM_MASTER-1:0] HBUSREQ,
    input  logic [NUM_MASTER-1:0] HLOCK,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
`ifdef AMBA_AHB_ARB_SPLIT_EN
    input  logic [1:0]            HRESP,
    input  logic [NUM_MASTER-1:0] HSPLIT,
`endif
    output logic [NUM_MASTER-1:0] HGRANT,
    output logic [3:0]            HMASTER,
    output logic                  HMASTLOCK
);

    localparam int IDXW  = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
    localparam int DEF_I = (DEFAULT_MASTER < NUM_MASTER) ? DEFAULT_MASTER : 0;
    localparam logic [IDXW-1:0]       DEF_IDX    = IDXW'(DEF_I);
    localparam logic [NUM_MASTER-1:0] DEF_ONEHOT = NUM_MASTER'(1) << DEF_I;

    logic [NUM_MASTER-1:0] r_grant;
    logic [3:0]            r_master;
    logic                  r_mastlock;
    logic [3:0]            r_beat_cnt;
    logic [IDXW-1:0]       r_rr_ptr;

    logic [IDXW-1:0]       w_grant_idx;
    logic [3:0]            w_beat_next;
    logic [NUM_MASTER-1:0] w_req;
    logic                  w_split_rsp;
    logic                  w_force_arb;
    logic                  w_arb;
    logic [IDXW-1:0]       w_win_idx;
    logic                  w_win_found;
    logic [NUM_MASTER-1:0] w_win_onehot;
    int                    w_scan_pos;
    logic [IDXW-1:0]       w_scan_sel;

`ifdef AMBA_AHB_ARB_SPLIT_EN
    logic [NUM_MASTER-1:0] r_split_mask;
    logic [NUM_MASTER-1:0] w_split_mask_next;
    logic                  r_force_arb;

    assign w_split_rsp = (HRESP == 2'b11) && !HREADY;
    assign w_force_arb = r_force_arb;
    assign w_req       = HBUSREQ & ~r_split_mask;

    // Clearing via HSPLIT takes precedence over a SPLIT response on the same edge.
    genvar gi;
    for (gi = 0; gi < NUM_MASTER; gi++) begin : g_split
        assign w_split_mask_next[gi] = !HSPLIT[gi] &&
            (r_split_mask[gi] || (w_split_rsp && (r_master == 4'(gi))));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_split_mask <= '0;
            r_force_arb  <= 1'b0;
        end else begin
            r_split_mask <= w_split_mask_next;
            if (HREADY)
                r_force_arb <= 1'b0;
            else if (w_split_rsp)
                r_force_arb <= 1'b1;
        end
    end
`else
    assign w_split_rsp = 1'b0;
    assign w_force_arb = 1'b0;
    assign w_req       = HBUSREQ;
`endif

    always_comb begin
        w_grant_idx = '0;
        for (int k = 0; k < NUM_MASTER; k++) begin
            if (r_grant[k])
                w_grant_idx = IDXW'(k);
        end
    end

    // Counter value after this edge assuming HREADY=1; reaching zero opens arbitration.
    always_comb begin
        w_beat_next = r_beat_cnt;
        case (HTRANS)
            2'b00: w_beat_next = 4'd0;
            2'b01: w_beat_next = r_beat_cnt;
            2'b10: begin
                case (HBURST)
                    3'b000, 3'b001: w_beat_next = 4'd0;
                    3'b010, 3'b011: w_beat_next = 4'd3;
                    3'b100, 3'b101: w_beat_next = 4'd7;
                    default:        w_beat_next = 4'd15;
                endcase
            end
            default: begin
                if (r_beat_cnt != 4'd0)
                    w_beat_next = r_beat_cnt - 4'd1;
            end
        endcase
    end

    assign w_arb = HREADY && ((w_beat_next == 4'd0) || w_force_arb) && !HLOCK[w_grant_idx];

    always_comb begin
        w_win_idx   = DEF_IDX;
        w_win_found = 1'b0;
        w_scan_pos  = 0;
        w_scan_sel  = '0;
        if (ROUND_ROBIN != 0) begin
            for (int k = 1; k <= NUM_MASTER; k++) begin
                w_scan_pos = (int'(r_rr_ptr) + k) % NUM_MASTER;
                w_scan_sel = IDXW'(w_scan_pos);
                if (!w_win_found && w_req[w_scan_sel]) begin
                    w_win_found = 1'b1;
                    w_win_idx   = w_scan_sel;
                end
            end
        end else begin
            for (int k = NUM_MASTER - 1; k >= 0; k--) begin
                w_scan_sel = IDXW'(k);
                if (w_req[w_scan_sel]) begin
                    w_win_found = 1'b1;
                    w_win_idx   = w_scan_sel;
                end
            end
        end
    end

    always_comb begin
        w_win_onehot            = '0;
        w_win_onehot[w_win_idx] = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant    <= DEF_ONEHOT;
            r_master   <= 4'(DEF_IDX);
            r_mastlock <= 1'b0;
            r_beat_cnt <= 4'd0;
            r_rr_ptr   <= DEF_IDX;
        end else if (HREADY) begin
            r_master   <= 4'(w_grant_idx);
            r_mastlock <= HLOCK[w_grant_idx];
            r_beat_cnt <= w_beat_next;
            if (w_arb) begin
                r_grant <= w_win_onehot;
                if (w_win_found)
                    r_rr_ptr <= w_win_idx;
            end
        end else if (w_split_rsp) begin
            r_beat_cnt <= 4'd0;
        end
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastlock;

endmodule
